// File: rtl/comm_pkg.sv
// ============================================================================
// Module   : comm_pkg
// Brief    : Shared state encodings, pin indices and parity helper for the
//            uart_comm_ic tile.
// Revision : 1.0
// ============================================================================
`default_nettype none

package comm_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   localparam int UI_RX       = 0;
   localparam int UI_TX_WR    = 1;
   localparam int UI_RX_RD    = 2;
   localparam int UI_PAR_EN   = 3;
   localparam int UI_PAR_ODD  = 4;
   localparam int UI_RD_MODE  = 5;
   localparam int UI_CLR_ERR  = 6;

   localparam int UO_TX        = 0;
   localparam int UO_TX_FULL   = 1;
   localparam int UO_RX_EMPTY  = 2;
   localparam int UO_PAR_ERR   = 3;
   localparam int UO_OVERRUN   = 4;
   localparam int UO_FRAME_ERR = 5;
   localparam int UO_TX_BUSY   = 6;
   localparam int UO_RX_VALID  = 7;

   // XOR of the low nbits of data, inverted for odd parity
   function automatic logic parity_fn(input logic [7:0] data, input int nbits, input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < 8; i++) begin
         if (i < nbits) p = p ^ data[i];
      end
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with count-based full/empty; head reads 0
//            when empty and a pop frees a slot for a same-cycle push.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~w_empty;
   assign w_do_push = i_push & (~w_full | i_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/uart_comm_ic.sv
// ============================================================================
// Module   : uart_comm_ic
// Brief    : Full-duplex UART tile top: strobe synchronisers, TX/RX engines,
//            TX/RX FIFOs, sticky error flags and the uio byte port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_comm_ic
   import comm_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int TX_DEPTH     = 4,
   parameter int RX_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int HALF  = CLKS_PER_BIT / 2;

   // ---------------- synchronisers: {clr, rx_rd, tx_wr, rx} ----------------
   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] r_sync_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_sync_prev <= '0;
      end else begin
         r_sync1     <= {ui_in[UI_CLR_ERR], ui_in[UI_RX_RD], ui_in[UI_TX_WR], ui_in[UI_RX]};
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
      end
   end

   logic w_rx_s;
   logic w_rx_fall;
   logic w_wr_pulse;
   logic w_rd_pulse;
   logic w_clr_pulse;

   assign w_rx_s      = r_sync2[0];
   assign w_rx_fall   = r_sync_prev[0] & ~r_sync2[0];
   assign w_wr_pulse  = r_sync2[1] & ~r_sync_prev[1];
   assign w_rd_pulse  = r_sync2[2] & ~r_sync_prev[2];
   assign w_clr_pulse = r_sync2[3] & ~r_sync_prev[3];

   // ---------------- FIFOs ----------------
   logic [DATA_BITS-1:0] w_tx_head;
   logic                 w_tx_full;
   logic                 w_tx_empty;
   logic                 w_tx_pop;
   logic [DATA_BITS-1:0] w_rx_head;
   logic                 w_rxf_full;
   logic                 w_rxf_empty;
   logic                 w_rx_push;
   logic [DATA_BITS-1:0] r_rx_shift;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_wr_pulse),
      .i_data  (uio_in[DATA_BITS-1:0]),
      .i_pop   (w_tx_pop),
      .o_data  (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty)
   );

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_rx_push),
      .i_data  (r_rx_shift),
      .i_pop   (w_rd_pulse),
      .o_data  (w_rx_head),
      .o_full  (w_rxf_full),
      .o_empty (w_rxf_empty)
   );

   // ---------------- TX engine ----------------
   tx_state_t            r_tx_state;
   tx_state_t            w_tx_next;
   logic [CNT_W-1:0]     r_tx_cnt;
   logic [2:0]           r_tx_bit;
   logic [DATA_BITS-1:0] r_tx_shift;
   logic                 r_tx_par;
   logic                 r_tx_par_en;
   logic                 w_tx_line;
   logic                 w_tx_bit_end;

   assign w_tx_bit_end = (r_tx_cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_comb begin
      w_tx_next = r_tx_state;
      w_tx_pop  = 1'b0;
      w_tx_line = 1'b1;
      case (r_tx_state)
         TX_IDLE: begin
            if (!w_tx_empty) begin
               w_tx_next = TX_START;
               w_tx_pop  = 1'b1;
            end
         end
         TX_START: begin
            w_tx_line = 1'b0;
            if (w_tx_bit_end) w_tx_next = TX_DATA;
         end
         TX_DATA: begin
            w_tx_line = r_tx_shift[0];
            if (w_tx_bit_end && r_tx_bit == 3'(DATA_BITS - 1))
               w_tx_next = r_tx_par_en ? TX_PARITY : TX_STOP;
         end
         TX_PARITY: begin
            w_tx_line = r_tx_par;
            if (w_tx_bit_end) w_tx_next = TX_STOP;
         end
         TX_STOP: begin
            if (w_tx_bit_end && r_tx_bit == 3'(STOP_BITS - 1)) w_tx_next = TX_IDLE;
         end
         default: w_tx_next = TX_IDLE;
      endcase
   end

   // Frame config and data are captured at the pop so mid-frame pin changes are ignored
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tx_state  <= TX_IDLE;
         r_tx_cnt    <= '0;
         r_tx_bit    <= '0;
         r_tx_shift  <= '0;
         r_tx_par    <= 1'b0;
         r_tx_par_en <= 1'b0;
      end else begin
         r_tx_state <= w_tx_next;
         if (r_tx_state == TX_IDLE || w_tx_bit_end) r_tx_cnt <= '0;
         else                                       r_tx_cnt <= r_tx_cnt + 1'b1;
         if (w_tx_pop) begin
            r_tx_shift  <= w_tx_head;
            r_tx_par    <= parity_fn(8'(w_tx_head), DATA_BITS, ui_in[UI_PAR_ODD]);
            r_tx_par_en <= ui_in[UI_PAR_EN];
            r_tx_bit    <= '0;
         end else if (r_tx_state == TX_DATA && w_tx_bit_end) begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= (r_tx_bit == 3'(DATA_BITS - 1)) ? 3'd0 : r_tx_bit + 3'd1;
         end else if (r_tx_state == TX_STOP && w_tx_bit_end) begin
            r_tx_bit <= r_tx_bit + 3'd1;
         end
      end
   end

   // ---------------- RX engine ----------------
   rx_state_t        r_rx_state;
   rx_state_t        w_rx_next;
   logic [CNT_W-1:0] r_rx_cnt;
   logic [2:0]       r_rx_bit;
   logic             r_rx_par_bit;
   logic             r_rx_par_en;
   logic             r_rx_odd;
   logic             r_rx_stop_bad;
   logic             w_rx_half;
   logic             w_rx_mid;
   logic             w_rx_par_bad;
   logic             w_set_pe;
   logic             w_set_ovr;
   logic             w_set_fe;

   assign w_rx_half    = (r_rx_cnt == CNT_W'(HALF - 1));
   assign w_rx_mid     = (r_rx_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_rx_par_bad = r_rx_par_en &
                         (parity_fn(8'(r_rx_shift), DATA_BITS, r_rx_odd) != r_rx_par_bit);

   always_comb begin
      w_rx_next = r_rx_state;
      w_rx_push = 1'b0;
      w_set_pe  = 1'b0;
      w_set_ovr = 1'b0;
      w_set_fe  = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            if (w_rx_fall) w_rx_next = RX_START;
         end
         RX_START: begin
            if (w_rx_half) w_rx_next = w_rx_s ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (w_rx_mid && r_rx_bit == 3'(DATA_BITS - 1))
               w_rx_next = r_rx_par_en ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: begin
            if (w_rx_mid) w_rx_next = RX_STOP;
         end
         RX_STOP: begin
            // A low stop bit parks here until the line returns high
            if (r_rx_stop_bad) begin
               if (w_rx_s) w_rx_next = RX_IDLE;
            end else if (w_rx_mid) begin
               if (!w_rx_s) begin
                  w_set_fe = 1'b1;
               end else begin
                  w_rx_next = RX_IDLE;
                  if (w_rx_par_bad) begin
                     w_set_pe = 1'b1;
                  end else begin
                     w_rx_push = 1'b1;
                     w_set_ovr = w_rxf_full & ~w_rd_pulse;
                  end
               end
            end
         end
         default: w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_state    <= RX_IDLE;
         r_rx_cnt      <= '0;
         r_rx_bit      <= '0;
         r_rx_shift    <= '0;
         r_rx_par_bit  <= 1'b0;
         r_rx_par_en   <= 1'b0;
         r_rx_odd      <= 1'b0;
         r_rx_stop_bad <= 1'b0;
      end else begin
         r_rx_state <= w_rx_next;
         if (r_rx_state == RX_IDLE)                         r_rx_cnt <= '0;
         else if (r_rx_state == RX_START ? w_rx_half : w_rx_mid) r_rx_cnt <= '0;
         else                                               r_rx_cnt <= r_rx_cnt + 1'b1;
         if (r_rx_state == RX_IDLE && w_rx_fall) begin
            r_rx_par_en <= ui_in[UI_PAR_EN];
            r_rx_odd    <= ui_in[UI_PAR_ODD];
            r_rx_bit    <= '0;
         end
         if (r_rx_state == RX_DATA && w_rx_mid) begin
            r_rx_shift <= {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end
         if (r_rx_state == RX_PARITY && w_rx_mid) r_rx_par_bit <= w_rx_s;
         if (r_rx_state != RX_STOP) r_rx_stop_bad <= 1'b0;
         else if (w_set_fe)         r_rx_stop_bad <= 1'b1;
      end
   end

   // ---------------- sticky error flags (set beats clear) ----------------
   logic r_par_err;
   logic r_overrun;
   logic r_frame_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_par_err   <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_par_err   <= w_set_pe  ? 1'b1 : (w_clr_pulse ? 1'b0 : r_par_err);
         r_overrun   <= w_set_ovr ? 1'b1 : (w_clr_pulse ? 1'b0 : r_overrun);
         r_frame_err <= w_set_fe  ? 1'b1 : (w_clr_pulse ? 1'b0 : r_frame_err);
      end
   end

   // ---------------- pin mapping ----------------
   always_comb begin
      uo_out               = '0;
      uo_out[UO_TX]        = w_tx_line;
      uo_out[UO_TX_FULL]   = w_tx_full;
      uo_out[UO_RX_EMPTY]  = w_rxf_empty;
      uo_out[UO_PAR_ERR]   = r_par_err;
      uo_out[UO_OVERRUN]   = r_overrun;
      uo_out[UO_FRAME_ERR] = r_frame_err;
      uo_out[UO_TX_BUSY]   = (r_tx_state != TX_IDLE);
      uo_out[UO_RX_VALID]  = ~w_rxf_empty;
   end

   assign uio_out = ui_in[UI_RD_MODE] ? 8'(w_rx_head) : 8'h00;
   assign uio_oe  = {8{ui_in[UI_RD_MODE]}};

   logic w_unused_inputs;
   assign w_unused_inputs = ^{ena, ui_in[7], uio_in};

endmodule

`default_nettype wire

// File: tb/tb_uart_comm_ic.sv
// ============================================================================
// Module   : tb_uart_comm_ic
// Brief    : Self-checking bench for uart_comm_ic with a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_comm_ic;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       rxl = 1'b1, wr = 1'b0, rd = 1'b0, pen = 1'b0, odd = 1'b0, rdm = 1'b0, clr = 1'b0;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   assign ui_in = {1'b0, clr, rdm, odd, pen, rd, wr, rxl};

   always #5 clk = ~clk;

   uart_comm_ic dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [11:0] got_q[$];
   logic [7:0]  rxq[$];
   logic [7:0]  tx_bytes[$];
   bit          m_pe, m_ovr, m_fe;
   logic [11:0] mon_raw;
   int          mon_nb;
   int          busy_cnt;
   logic [7:0]  d;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected serial frame, bit k = k-th bit on the line (start first)
   function automatic logic [11:0] frame_model(input logic [7:0] b, input bit p_en, input bit p_odd);
      logic [11:0] r;
      r      = '0;
      r[8:1] = b;
      if (p_en) begin
         r[9]  = (^b) ^ p_odd;
         r[10] = 1'b1;
      end else begin
         r[9] = 1'b1;
      end
      return r;
   endfunction

   // TX line decoder: samples each bit at its middle
   initial begin
      forever begin
         tick();
         if (rst_n === 1'b1 && uo_out[0] === 1'b0) begin
            mon_nb  = 10 + int'(pen);
            mon_raw = '0;
            repeat (8) tick();
            for (int k = 0; k < mon_nb; k++) begin
               mon_raw[k] = uo_out[0];
               if (k < mon_nb - 1) repeat (16) tick();
            end
            got_q.push_back(mon_raw);
         end
      end
   end

   task automatic wr_byte(input logic [7:0] b);
      uio_in = b;
      wr = 1'b1; tick(); tick();
      wr = 1'b0; tick(); tick();
   endtask

   task automatic wait_frame(input string tag, input logic [11:0] exp);
      for (int i = 0; i < 400 && got_q.size() == 0; i++) tick();
      chk({tag, "_seen"}, 32'(got_q.size() != 0), 32'd1);
      if (got_q.size() != 0) chk(tag, 32'(got_q.pop_front()), 32'(exp));
   endtask

   task automatic rx_bit(input logic b);
      rxl = b;
      repeat (16) tick();
   endtask

   task automatic rx_send(input logic [7:0] b, input bit p_en, input bit p_odd,
                          input bit bad_par, input bit bad_stop);
      pen = p_en;
      odd = p_odd;
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(b[i]);
      if (p_en) rx_bit((^b) ^ p_odd ^ bad_par);
      rx_bit(!bad_stop);
      rxl = 1'b1;
      repeat (20) tick();
      if (bad_stop)                 m_fe = 1'b1;
      else if (p_en && bad_par)     m_pe = 1'b1;
      else if (rxq.size() == 4)     m_ovr = 1'b1;
      else                          rxq.push_back(b);
      pen = 1'b0;
      odd = 1'b0;
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_pe"},       32'(uo_out[3]), 32'(m_pe));
      chk({tag, "_ovr"},      32'(uo_out[4]), 32'(m_ovr));
      chk({tag, "_fe"},       32'(uo_out[5]), 32'(m_fe));
      chk({tag, "_rx_empty"}, 32'(uo_out[2]), 32'(rxq.size() == 0));
      chk({tag, "_rx_valid"}, 32'(uo_out[7]), 32'(rxq.size() != 0));
   endtask

   task automatic rx_read(input string tag);
      rdm = 1'b1;
      tick();
      chk({tag, "_oe"}, 32'(uio_oe), 32'hFF);
      chk(tag, 32'(uio_out), 32'(rxq[0]));
      rd = 1'b1; tick(); tick();
      rd = 1'b0; tick(); tick();
      void'(rxq.pop_front());
      rdm = 1'b0;
   endtask

   task automatic clear_errs();
      clr = 1'b1; tick(); tick();
      clr = 1'b0; tick(); tick();
      m_pe = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
   endtask

   initial begin
      m_pe = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;

      rst_n = 1'b0;
      tick(); tick();
      chk("rst_uo_out",  32'(uo_out),  32'h05);
      chk("rst_uio_out", 32'(uio_out), 32'h00);
      chk("rst_uio_oe",  32'(uio_oe),  32'h00);
      rst_n = 1'b1;
      tick();

      // Strobe-to-start latency and frame length for 0xA5
      uio_in = 8'hA5;
      wr = 1'b1; tick(); tick();
      wr = 1'b0; tick();
      chk("pre_start_tx",   32'(uo_out[0]), 32'd1);
      chk("pre_start_busy", 32'(uo_out[6]), 32'd0);
      tick();
      chk("start_tx",   32'(uo_out[0]), 32'd0);
      chk("start_busy", 32'(uo_out[6]), 32'd1);
      busy_cnt = 0;
      for (int i = 0; i < 400 && uo_out[6] === 1'b1; i++) begin
         busy_cnt++;
         tick();
      end
      chk("busy_len", 32'(busy_cnt), 32'd160);
      wait_frame("a5_frame", frame_model(8'hA5, 1'b0, 1'b0));

      // Random bytes with random parity configuration
      for (int n = 0; n < 4; n++) begin
         logic [7:0] b;
         b   = 8'($urandom);
         pen = 1'($urandom);
         odd = 1'($urandom);
         wr_byte(b);
         wait_frame("tx_rand", frame_model(b, pen, odd));
      end
      pen = 1'b0;
      odd = 1'b0;
      tick();

      // Six writes while the first frame is on the line: one is dropped
      tx_bytes.delete();
      for (int n = 0; n < 6; n++) begin
         d = 8'($urandom);
         tx_bytes.push_back(d);
         wr_byte(d);
      end
      chk("tx_full", 32'(uo_out[1]), 32'd1);
      for (int n = 0; n < 5; n++) wait_frame("tx_fill", frame_model(tx_bytes[n], 1'b0, 1'b0));
      repeat (250) tick();
      chk("tx_extra_frames", 32'(got_q.size()), 32'd0);
      chk("tx_full_clear",   32'(uo_out[1]),    32'd0);

      // RX even parity, good then bad parity
      check_status("rx_init");
      rx_send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      check_status("rx_3c");
      rx_read("rx_3c_data");
      rx_send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
      check_status("rx_badpar");
      clear_errs();
      check_status("rx_clr1");

      // Random frames, random parity mode
      for (int n = 0; n < 3; n++) rx_send(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      check_status("rx_rand");
      while (rxq.size() != 0) rx_read("rx_rand_data");
      check_status("rx_rand_done");

      // Overrun: five frames into a four-entry FIFO
      for (int n = 0; n < 5; n++) rx_send(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      check_status("rx_ovr");
      while (rxq.size() != 0) rx_read("rx_ovr_data");
      rdm = 1'b1;
      tick();
      chk("empty_head", 32'(uio_out), 32'h00);
      rd = 1'b1; tick(); tick();
      rd = 1'b0; tick(); tick();
      rdm = 1'b0;
      check_status("rx_empty_pop");
      clear_errs();
      check_status("rx_clr2");

      // Start-bit glitch is ignored
      rxl = 1'b0; tick(); tick(); tick();
      rxl = 1'b1;
      repeat (40) tick();
      check_status("rx_glitch");

      // Low stop bit
      rx_send(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
      check_status("rx_frame_err");
      clear_errs();
      check_status("rx_clr3");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
